// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, flush and memory-wait freeze controller
module hazard_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 mem_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 pc_stall,
    output logic                 pc_src,
    output logic                 ifid_hold,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 pipe_freeze,
    output logic                 halt,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [15:0]          TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        mem_stall, freeze, branch_ev, load_use, rs_match;

    always_comb begin
        mem_stall    = mem_req & ~mem_ack;
        rs_match     = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        // rst_n gates every event so the controls read all-zero while in reset
        freeze       = rst_n & (mem_stall | (state == HALT));
        branch_ev    = rst_n & mem_branch_taken & ~freeze;
        load_use     = rst_n & ex_mem_read & (ex_rd != 5'd0) & rs_match & ~freeze & ~branch_ev;

        pipe_freeze  = freeze;
        pc_stall     = freeze | load_use;
        ifid_hold    = freeze | load_use;
        pc_src       = branch_ev;
        ifid_flush   = branch_ev;
        idex_flush   = branch_ev | load_use;
        exmem_flush  = branch_ev;

        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack || !mem_req) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_nxt    = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    assign halt = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= 16'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (pc_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_ONE;
            if (branch_ev && flush_events != '1)
                flush_events <= flush_events + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       mem_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

    logic        pc_stall_a, pc_src_a, ifid_hold_a, ifid_flush_a, idex_flush_a, exmem_flush_a, pipe_freeze_a, halt_a;
    logic        pc_stall_b, pc_src_b, ifid_hold_b, ifid_flush_b, idex_flush_b, exmem_flush_b, pipe_freeze_b, halt_b;
    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;
    logic [6:0]  ctrl_a, ctrl_b;

    assign ctrl_a = {pc_stall_a, pc_src_a, ifid_hold_a, ifid_flush_a, idex_flush_a, exmem_flush_a, pipe_freeze_a};
    assign ctrl_b = {pc_stall_b, pc_src_b, ifid_hold_b, ifid_flush_b, idex_flush_b, exmem_flush_b, pipe_freeze_b};

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_stall(pc_stall_a), .pc_src(pc_src_a),
        .ifid_hold(ifid_hold_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
        .exmem_flush(exmem_flush_a), .pipe_freeze(pipe_freeze_a), .halt(halt_a),
        .stall_cycles(stall_a), .flush_events(flush_a));

    hazard_ctrl #(.TIMEOUT(TO), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_stall(pc_stall_b), .pc_src(pc_src_b),
        .ifid_hold(ifid_hold_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
        .exmem_flush(exmem_flush_b), .pipe_freeze(pipe_freeze_b), .halt(halt_b),
        .stall_cycles(stall_b), .flush_events(flush_b));

    // {pc_stall, pc_src, ifid_hold, ifid_flush, idex_flush, exmem_flush, pipe_freeze}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_FRZ  = 7'b1010001;
    localparam logic [6:0] C_BR   = 7'b0101110;
    localparam logic [6:0] C_LU   = 7'b1010100;

    typedef struct {
        logic       br, mr, ma, emr, u1, u2;
        logic [4:0] exrd, rs1, rs2;
        logic [6:0] exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic   m_halt;
    int     m_wait;
    longint m_stall, m_flush;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic br, input logic mr, input logic ma, input logic emr,
                         input logic [4:0] exrd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        mem_branch_taken = br; mem_req = mr; mem_ack = ma; ex_mem_read = emr;
        ex_rd = exrd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    function automatic logic [6:0] model_ctrl();
        logic lu;
        if (!rst_n) return C_IDLE;
        if (m_halt || (mem_req && !mem_ack)) return C_FRZ;
        if (mem_branch_taken) return C_BR;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        return lu ? C_LU : C_IDLE;
    endfunction

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    // Compare both instances against the model, then advance the model one edge.
    task automatic model_cycle();
        logic [6:0] e;
        @(negedge clk);
        if (!rst_n) begin
            m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end
        e = model_ctrl();
        check("rnd_ctrl_a", 32'(ctrl_a), 32'(e));
        check("rnd_ctrl_b", 32'(ctrl_b), 32'(e));
        check("rnd_halt", 32'({halt_a, halt_b}), m_halt ? 32'd3 : 32'd0);
        check("rnd_stall_a", stall_a, 32'(sat(m_stall, 64'hFFFF_FFFF)));
        check("rnd_flush_a", flush_a, 32'(sat(m_flush, 64'hFFFF_FFFF)));
        check("rnd_stall_b", 32'(stall_b), 32'(sat(m_stall, 15)));
        check("rnd_flush_b", 32'(flush_b), 32'(sat(m_flush, 15)));
        if (rst_n) begin
            if (e[6]) m_stall++;
            if (e[5]) m_flush++;
            if (!m_halt) begin
                if (mem_req && !mem_ack) begin
                    if (m_wait >= TO) m_halt = 1;
                    else m_wait++;
                end else begin
                    m_wait = 0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[12];
    int   waited;

    initial begin
        vecs[0]  = '{br:0, mr:0, ma:0, emr:0, u1:0, u2:0, exrd:0, rs1:0, rs2:0, exp:C_IDLE};
        vecs[1]  = '{br:0, mr:0, ma:0, emr:1, u1:1, u2:0, exrd:5, rs1:5, rs2:0, exp:C_LU};
        vecs[2]  = '{br:0, mr:0, ma:0, emr:1, u1:1, u2:0, exrd:0, rs1:0, rs2:0, exp:C_IDLE};
        vecs[3]  = '{br:0, mr:0, ma:0, emr:1, u1:0, u2:0, exrd:5, rs1:5, rs2:0, exp:C_IDLE};
        vecs[4]  = '{br:0, mr:0, ma:0, emr:1, u1:0, u2:1, exrd:9, rs1:3, rs2:9, exp:C_LU};
        vecs[5]  = '{br:0, mr:0, ma:0, emr:0, u1:1, u2:1, exrd:7, rs1:7, rs2:7, exp:C_IDLE};
        vecs[6]  = '{br:1, mr:0, ma:0, emr:0, u1:0, u2:0, exrd:0, rs1:0, rs2:0, exp:C_BR};
        vecs[7]  = '{br:1, mr:0, ma:0, emr:1, u1:1, u2:0, exrd:5, rs1:5, rs2:0, exp:C_BR};
        vecs[8]  = '{br:0, mr:1, ma:0, emr:0, u1:0, u2:0, exrd:0, rs1:0, rs2:0, exp:C_FRZ};
        vecs[9]  = '{br:1, mr:1, ma:1, emr:0, u1:0, u2:0, exrd:0, rs1:0, rs2:0, exp:C_BR};
        vecs[10] = '{br:1, mr:1, ma:0, emr:1, u1:1, u2:0, exrd:5, rs1:5, rs2:0, exp:C_FRZ};
        vecs[11] = '{br:0, mr:0, ma:1, emr:1, u1:0, u2:1, exrd:31, rs1:0, rs2:31, exp:C_LU};

        // reset state, with a memory stall pending on the inputs
        apply(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        #2;
        check("reset_ctrl", 32'(ctrl_a), 32'(C_IDLE));
        check("reset_halt_cnt", {halt_a, stall_a[30:0]}, 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            apply(vecs[i].br, vecs[i].mr, vecs[i].ma, vecs[i].emr, vecs[i].exrd,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2);
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_a), 32'(vecs[i].exp));
            next_cycle();
        end

        // single load-use: one bubble, one stall cycle
        do_reset();
        apply(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        @(negedge clk); check("lu_ctrl", 32'(ctrl_a), 32'(C_LU));
        next_cycle(); idle();
        @(negedge clk); check("lu_after", 32'(ctrl_a), 32'(C_IDLE));
        check("lu_stall_cnt", stall_a, 32'd1);

        // branch wins over load-use
        do_reset();
        apply(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        @(negedge clk); check("br_lu_ctrl", 32'(ctrl_a), 32'(C_BR));
        next_cycle(); idle();
        @(negedge clk);
        check("br_lu_flush_cnt", flush_a, 32'd1);
        check("br_lu_stall_cnt", stall_a, 32'd0);

        // three wait cycles then ack
        do_reset();
        apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check($sformatf("wait%0d_freeze", i), 32'(ctrl_a), 32'(C_FRZ));
            next_cycle();
        end
        mem_ack = 1'b1;
        @(negedge clk); check("ack_cycle_ctrl", 32'(ctrl_a), 32'(C_IDLE));
        next_cycle(); idle();
        @(negedge clk);
        check("ack_stall_cnt", stall_a, 32'd3);
        check("ack_no_halt", 32'(halt_a), 32'd0);

        // branch held during a freeze takes effect in the ack cycle only
        do_reset();
        apply(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check($sformatf("br_frz%0d_pc_src", i), 32'(pc_src_a), 32'd0);
            next_cycle();
        end
        mem_ack = 1'b1;
        @(negedge clk); check("br_ack_ctrl", 32'(ctrl_a), 32'(C_BR));
        next_cycle(); idle();
        @(negedge clk);
        check("br_ack_pc_src_once", 32'(pc_src_a), 32'd0);
        check("br_ack_flush_cnt", flush_a, 32'd1);

        // timeout: halt after the edge where the wait count reaches TIMEOUT
        do_reset();
        apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        waited = 0;
        while (!halt_a && waited < 20) begin
            next_cycle();
            waited++;
        end
        check("halt_latency", 32'(waited), 32'(TO + 1));
        apply(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        next_cycle();
        @(negedge clk);
        check("halt_sticky", 32'(halt_a), 32'd1);
        check("halt_ctrl", 32'(ctrl_a), 32'(C_FRZ));
        apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        rst_n = 1'b0; #1;
        check("rst_in_halt_ctrl", 32'(ctrl_a), 32'(C_IDLE));
        check("rst_in_halt_state", {halt_a, stall_a[30:0]}, 32'd0);
        check("rst_in_halt_flush", flush_a, 32'd0);
        idle();
        next_cycle(); rst_n = 1'b1;
        next_cycle(); next_cycle();
        @(negedge clk);
        check("post_rst_run", 32'({halt_a, ctrl_a}), 32'd0);

        // saturation of the 4-bit counter
        do_reset();
        apply(0, 0, 0, 1, 5'd3, 5'd0, 5'd3, 0, 1);
        for (int i = 0; i < 20; i++) next_cycle();
        @(negedge clk);
        check("sat_stall_b", 32'(stall_b), 32'd15);
        check("sat_stall_a", stall_a, 32'd20);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0)
                rst_n = 1'b0;
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req          = ($urandom_range(0, 2) == 0);
            mem_ack          = ($urandom_range(0, 9) < 4);
            ex_mem_read      = ($urandom_range(0, 1) == 0);
            ex_rd            = 5'($urandom_range(0, 3));
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            id_use_rs1       = ($urandom_range(0, 1) == 0);
            id_use_rs2       = ($urandom_range(0, 1) == 0);
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
